// File: rtl/music_pkg.sv
// Shared types and constants for the note-sequencer controller.
package music_pkg;

  localparam int ADDR_W = 6;
  localparam int NOTE_W = 5;

  localparam logic [NOTE_W-1:0] END_CODE  = 5'd31;
  localparam logic [NOTE_W-1:0] REST_CODE = 5'd0;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_PAUSE
  } state_e;

endpackage

// File: rtl/ms_tick.sv
// Free-running millisecond strobe: one-cycle pulse every CLK_FREQ/1000 clocks.
module ms_tick #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int DIV = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/music_player_ctrl.sv
// Note-sequencer controller: walks note memory, times beats/gaps on ms ticks.
// Define MUSIC_LOOP_EN to restart the song at address 0 instead of idling.
module music_player_ctrl
  import music_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BEAT_MS  = 250,
  parameter int GAP_MS   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [NOTE_W-1:0] music,
  output logic [ADDR_W-1:0] cnt,
  output logic [NOTE_W-1:0] note,
  output logic              mute,
  output logic              busy,
  output logic              done
);

  localparam int MS_MAX = (BEAT_MS > GAP_MS) ? BEAT_MS : GAP_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam logic [MS_W-1:0] BEAT_LAST = MS_W'(BEAT_MS - 1);
  localparam logic [MS_W-1:0] GAP_LAST  = MS_W'(GAP_MS - 1);

`ifdef MUSIC_LOOP_EN
  localparam state_e END_NEXT = ST_FETCH;
`else
  localparam state_e END_NEXT = ST_IDLE;
`endif

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic                tick;
  logic                end_song;

  ms_tick #(.CLK_FREQ(CLK_FREQ)) u_ms_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // NOTE: every *_d gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    ms_d     = ms_q;
    cnt_d    = cnt_q;
    note_d   = note_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    end_song = 1'b0;

    unique case (state_q)
      ST_IDLE: if (play) begin
        state_d = ST_FETCH;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
      ST_FETCH: begin
        if (pause) pend_d = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (music == END_CODE) begin
          end_song = 1'b1;
        end else begin
          note_d = music;
          ms_d   = '0;
          pend_d = 1'b0;
          // A pause seen while the note was being fetched parks at beat start.
          if (pause || pend_q) begin
            state_d = ST_PAUSE;
            ret_d   = ST_PLAY;
          end else begin
            state_d = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (pause) begin
          state_d = ST_PAUSE;
          ret_d   = ST_PLAY;
        end else if (tick) begin
          if (ms_q == BEAT_LAST) begin
            state_d = ST_GAP;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (pause) begin
          state_d = ST_PAUSE;
          ret_d   = ST_GAP;
        end else if (tick) begin
          if (ms_q == GAP_LAST) begin
            if (cnt_q == LAST_ADDR) begin
              end_song = 1'b1;
            end else begin
              cnt_d   = cnt_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
      end
      ST_PAUSE: if (play) state_d = ret_q;
      default:  state_d = ST_IDLE;
    endcase

    if (end_song) begin
      done_d  = 1'b1;
      cnt_d   = '0;
      pend_d  = 1'b0;
      state_d = END_NEXT;
    end

    // Stop outranks everything, including a song ending in the same cycle.
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      note_d  = '0;
      ms_d    = '0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // NOTE: non-blocking here so every flop samples the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_PLAY;
      ms_q    <= '0;
      cnt_q   <= '0;
      note_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      ms_q    <= ms_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign note = note_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);
  assign mute = !((state_q == ST_PLAY) && (note_q != REST_CODE));

endmodule

// File: tb/tb_music_player_ctrl.sv
// Bench for music_player_ctrl: tick-level behavioural model plus directed scenarios.
// Beat length in clocks depends on where the free-running ms tick falls.
module tb_music_player_ctrl;

  localparam int CLK_FREQ = 4000;
  localparam int BEAT_MS  = 3;
  localparam int GAP_MS   = 1;
  localparam int DIV      = CLK_FREQ / 1000;
`ifdef MUSIC_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [4:0] music;
  logic [5:0] cnt;
  logic [4:0] note;
  logic       mute, busy, done;
  logic [4:0] mem [64];

  always #5 clk = ~clk;

  // Synchronous note memory: data follows the address by one clock.
  always @(posedge clk) music <= mem[cnt];

  music_player_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .BEAT_MS  (BEAT_MS),
    .GAP_MS   (GAP_MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .play  (play),
    .pause (pause),
    .stop  (stop),
    .music (music),
    .cnt   (cnt),
    .note  (note),
    .mute  (mute),
    .busy  (busy),
    .done  (done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_OFF, M_FETCH, M_LOAD, M_SOUND, M_SILENT, M_HELD} mphase_e;
  mphase_e m_ph, m_resume;
  int      m_cnt, m_note, m_left, k;
  bit      m_pend, m_done;

  function automatic void m_reset();
    m_ph = M_OFF; m_resume = M_SOUND;
    m_cnt = 0; m_note = 0; m_left = 0; m_pend = 0; m_done = 0;
  endfunction

  function automatic void m_finish();
    m_done = 1; m_cnt = 0; m_pend = 0;
    m_ph = LOOP ? M_FETCH : M_OFF;
  endfunction

  function automatic void m_step(input bit pl, input bit pa, input bit st, input bit tk);
    m_done = 0;
    if (st) begin
      m_ph = M_OFF; m_cnt = 0; m_note = 0; m_pend = 0;
      return;
    end
    case (m_ph)
      M_OFF:   if (pl) begin m_ph = M_FETCH; m_cnt = 0; m_pend = 0; end
      M_FETCH: begin if (pa) m_pend = 1; m_ph = M_LOAD; end
      M_LOAD: begin
        if (mem[m_cnt] == 5'd31) m_finish();
        else begin
          m_note = mem[m_cnt]; m_left = BEAT_MS;
          if (pa || m_pend) begin m_ph = M_HELD; m_resume = M_SOUND; m_pend = 0; end
          else m_ph = M_SOUND;
        end
      end
      M_SOUND: begin
        if (pa) begin m_resume = M_SOUND; m_ph = M_HELD; end
        else if (tk) begin
          m_left--;
          if (m_left == 0) begin m_ph = M_SILENT; m_left = GAP_MS; end
        end
      end
      M_SILENT: begin
        if (pa) begin m_resume = M_SILENT; m_ph = M_HELD; end
        else if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_cnt == 63) m_finish();
            else begin m_cnt++; m_ph = M_FETCH; end
          end
        end
      end
      M_HELD: if (pl) m_ph = m_resume;
      default: m_ph = M_OFF;
    endcase
  endfunction

  always @(posedge clk) if (rst_n) begin
    m_step(play, pause, stop, (k % DIV) == DIV - 1);
    k++;
  end

  always @(negedge rst_n) begin
    m_reset();
    k = 0;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cnt",  32'(cnt),  32'(m_cnt));
    check("note", 32'(note), 32'(m_note));
    check("mute", 32'(mute), 32'((m_ph == M_SOUND && m_note != 0) ? 0 : 1));
    check("busy", 32'(busy), 32'(m_ph != M_OFF));
    check("done", 32'(done), 32'(m_done));
  end

  // Mute-low run lengths and done pulses, for hand-computed expectations.
  int runs[$];
  int run = 0, done_cnt = 0, done_k = 0;

  always @(negedge clk) begin
    if (rst_n && !mute) run++;
    else if (run > 0) begin runs.push_back(run); run = 0; end
    if (done) begin done_cnt++; done_k = k - 1; end
  end

  function automatic void clear_mon();
    runs.delete(); run = 0; done_cnt = 0; done_k = 0;
  endfunction

  // ---------------- stimulus helpers (called at negedge+1) ----------------
  task automatic at_edge(input int e);
    int guard = 0;
    while (k < e && guard < 2000) begin @(negedge clk); guard++; end
    #1;
  endtask

  task automatic pulse(input bit pl, input bit pa, input bit st);
    play = pl; pause = pa; stop = st;
    @(negedge clk); #1;
    play = 0; pause = 0; stop = 0;
  endtask

  function automatic int next_phase();
    int e = k + 1;
    while (e % DIV != 1) e++;
    return e;
  endfunction

  task automatic wait_done(input int lim);
    int i = 0;
    while (done_cnt == 0 && i < lim) begin @(negedge clk); #1; i++; end
    if (done_cnt == 0) check("done_timeout", 0, 1);
  endtask

  task automatic go_idle();
    pulse(0, 0, 1);
    @(negedge clk); #1;
    clear_mon();
  endtask

  task automatic load_song(input int n, input logic [4:0] v0, input logic [4:0] v1, input logic [4:0] v2);
    for (int i = 0; i < 64; i++) mem[i] = 5'd31;
    if (n > 0) mem[0] = v0;
    if (n > 1) mem[1] = v1;
    if (n > 2) mem[2] = v2;
  endtask

  int P;

  initial begin
    m_reset();
    k = 0;
    for (int i = 0; i < 64; i++) mem[i] = 5'd31;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_mute", 32'(mute), 1);
    check("rst_cnt",  32'(cnt),  0);
    check("rst_note", 32'(note), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1;
    @(negedge clk); #1;

    // Two notes then end: 12-clock first beat, 10-clock second beat, done at +36.
    load_song(3, 5'd5, 5'd7, 5'd31);
    go_idle();
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    wait_done(300);
    check("two_done_at", done_k - P, 36);
    check("two_busy_end", 32'(busy), 32'(LOOP));
    check("two_cnt_end", 32'(cnt), 0);
    check("two_runs", runs.size(), 2);
    if (runs.size() >= 2) begin
      check("two_run0", runs[0], 12);
      check("two_run1", runs[1], 10);
    end
    repeat (2) @(negedge clk); #1;
    check("two_done_once", done_cnt, 1);

    // Rest note stays muted; done after one beat plus gap.
    load_song(2, 5'd0, 5'd31, 5'd31);
    go_idle();
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    wait_done(200);
    check("rest_done_at", done_k - P, 20);
    check("rest_no_sound", runs.size(), 0);

    // Pause five clocks into the first beat, hold, resume for the remaining seven.
    load_song(3, 5'd5, 5'd7, 5'd31);
    go_idle();
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    at_edge(P + 7); pulse(0, 1, 0);
    at_edge(P + 30);
    check("pause_cnt",  32'(cnt),  0);
    check("pause_note", 32'(note), 5);
    check("pause_mute", 32'(mute), 1);
    check("pause_busy", 32'(busy), 1);
    at_edge(P + 59); pulse(1, 0, 0);
    wait_done(300);
    if (runs.size() >= 2) begin
      check("pause_run0", runs[0], 5);
      check("pause_run1", runs[1], 7);
    end else check("pause_runs", runs.size(), 2);

    // Stop and play together: stop wins, no done.
    go_idle();
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    at_edge(P + 5); pulse(1, 0, 1);
    check("stop_busy", 32'(busy), 0);
    check("stop_mute", 32'(mute), 1);
    check("stop_cnt",  32'(cnt),  0);
    check("stop_note", 32'(note), 0);
    repeat (40) @(negedge clk); #1;
    check("stop_no_done", done_cnt, 0);

    // Pause and play together: pause wins.
    go_idle();
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    at_edge(P + 5); pulse(1, 1, 0);
    at_edge(P + 25);
    check("pp_busy", 32'(busy), 1);
    check("pp_mute", 32'(mute), 1);
    check("pp_cnt",  32'(cnt),  0);

    // Full 64-entry song without an end code.
    go_idle();
    for (int i = 0; i < 64; i++) mem[i] = 5'($urandom_range(1, 30));
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    wait_done(3000);
    check("full_cnt_end", 32'(cnt), 0);
    check("full_busy_end", 32'(busy), 32'(LOOP));
    check("full_runs", runs.size(), 64);

    // Reset in the gap after address 3, then restart from address 0.
    go_idle();
    for (int i = 0; i < 10; i++) mem[i] = 5'(i + 1);
    mem[10] = 5'd31;
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    begin
      int i = 0;
      while (!(m_ph == M_SILENT && m_cnt == 3) && i < 600) begin @(negedge clk); #1; i++; end
      if (!(m_ph == M_SILENT && m_cnt == 3)) check("gap3_timeout", 0, 1);
    end
    #2 rst_n = 0;
    #1;
    check("arst_cnt",  32'(cnt),  0);
    check("arst_note", 32'(note), 0);
    check("arst_mute", 32'(mute), 1);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    @(negedge clk); #1 rst_n = 1;
    clear_mon();
    P = next_phase(); at_edge(P); pulse(1, 0, 0);
    check("restart_cnt",  32'(cnt),  0);
    check("restart_busy", 32'(busy), 1);
    at_edge(P + 3);
    check("restart_note", 32'(note), 1);
    check("restart_mute", 32'(mute), 0);

    // Random pulse traffic over random songs.
    for (int r = 0; r < 6; r++) begin
      go_idle();
      for (int i = 0; i < 64; i++) mem[i] = 5'($urandom_range(0, 30));
      if (r != 5) mem[$urandom_range(1, 8)] = 5'd31;
      for (int c = 0; c < 500; c++) begin
        play  = ($urandom_range(0, 11) == 0);
        pause = ($urandom_range(0, 23) == 0);
        stop  = ($urandom_range(0, 99) == 0);
        @(negedge clk); #1;
      end
      play = 0; pause = 0; stop = 0;
    end

    go_idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
